// File: rtl/fp64_pcm_pkg.sv
// Shared types and constants for the binary64 to 16-bit PCM converter.
package fp64_pcm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StAlign,
    StRound,
    StDone,
    StWait
  } state_e;

  typedef enum logic [1:0] {
    ClsZero,
    ClsSat,
    ClsNorm
  } cls_e;

  localparam int unsigned EXP_BIAS = 1023;
  localparam int unsigned FRAC_W   = 52;
  localparam int unsigned EXP_NAN  = 2047;

  // |x| < 0.5 below EXP_HALF; |x| >= 32768 from EXP_SAT upwards
  localparam int unsigned EXP_HALF = EXP_BIAS - 1;
  localparam int unsigned EXP_SAT  = EXP_BIAS + 15;

  localparam logic signed [15:0] SAT_POS = 16'sh7FFF;
  localparam logic signed [15:0] SAT_NEG = 16'sh8000;

endpackage

// File: rtl/fp64_align_round.sv
// Aligns the binary64 mantissa to an integer magnitude and extracts the round bit.
module fp64_align_round
  import fp64_pcm_pkg::*;
(
  input  logic [10:0]       exp_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic [15:0]       mag_o,
  output logic              rnd_o
);

  logic [FRAC_W:0] mant;
  logic [5:0]      sh_m1;
  logic [16:0]     shifted;

  assign mant    = {1'b1, frac_i};
  // Shift one place short so the round bit lands at bit 0
  assign sh_m1   = 6'(11'(EXP_BIAS + FRAC_W - 1) - exp_i);
  assign shifted = 17'(mant >> sh_m1);
  assign mag_o   = shifted[16:1];
  assign rnd_o   = shifted[0];

endmodule

// File: rtl/fp64_to_pcm16.sv
// Multi-cycle binary64 to saturating 16-bit PCM converter, round half away from zero.
// Optional SAMPLE_ALIGN_EN holds the result until sampling_cycle_counter reaches 0.
module fp64_to_pcm16
  import fp64_pcm_pkg::*;
#(
  parameter int unsigned CNT_W = 13
) (
  input  logic             clk_operation,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] sampling_cycle_counter,
  input  logic [63:0]      double,
  output logic [15:0]      sig16b,
  output logic             ready,
  output logic             busy
);

  state_e      state_q, state_d;
  logic [63:0] in_q, in_d;
  cls_e        cls_q, cls_d;
  logic [15:0] mag_q, mag_d;
  logic        rnd_q, rnd_d;
  logic [15:0] res_q, res_d;
  logic [15:0] sig_q, sig_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic              sign;
  logic [10:0]       exp_f;
  logic [FRAC_W-1:0] frac_f;
  logic [15:0]       al_mag;
  logic              al_rnd;
  logic [15:0]       sum;
  logic [15:0]       round_val;
  cls_e              cls_val;

  assign sign   = in_q[63];
  assign exp_f  = in_q[62:52];
  assign frac_f = in_q[51:0];

`ifdef SAMPLE_ALIGN_EN
  logic [15:0] stage_q, stage_d;
  logic        cnt_zero;
  assign cnt_zero = (sampling_cycle_counter == '0);
`else
  logic unused_cnt;
  assign unused_cnt = ^sampling_cycle_counter;
`endif

  fp64_align_round u_align_round (
    .exp_i  (exp_f),
    .frac_i (frac_f),
    .mag_o  (al_mag),
    .rnd_o  (al_rnd)
  );

  always_comb begin
    cls_val = ClsNorm;
    if (exp_f == 11'(EXP_NAN)) begin
      cls_val = (frac_f != '0) ? ClsZero : ClsSat;
    end else if (exp_f < 11'(EXP_HALF)) begin
      cls_val = ClsZero;
    end else if (exp_f >= 11'(EXP_SAT)) begin
      cls_val = ClsSat;
    end
  end

  // Magnitude never exceeds 32768, so 16 bits hold the rounded sum
  assign sum = mag_q + {15'd0, rnd_q};

  always_comb begin
    round_val = '0;
    unique case (cls_q)
      ClsZero: round_val = '0;
      ClsSat:  round_val = sign ? SAT_NEG : SAT_POS;
      default: begin
        if (sign) begin
          round_val = -sum;
        end else begin
          round_val = sum[15] ? SAT_POS : sum;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    cls_d   = cls_q;
    mag_d   = mag_q;
    rnd_d   = rnd_q;
    res_d   = res_q;
    sig_d   = sig_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
`ifdef SAMPLE_ALIGN_EN
    stage_d = stage_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          in_d    = double;
          busy_d  = 1'b1;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        cls_d   = cls_val;
        state_d = StAlign;
      end
      StAlign: begin
        mag_d   = al_mag;
        rnd_d   = al_rnd;
        state_d = StRound;
      end
      StRound: begin
        res_d   = round_val;
        state_d = StDone;
      end
      StDone: begin
`ifdef SAMPLE_ALIGN_EN
        if (cnt_zero) begin
          sig_d   = res_q;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          stage_d = res_q;
          state_d = StWait;
        end
`else
        sig_d   = res_q;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
`endif
      end
`ifdef SAMPLE_ALIGN_EN
      StWait: begin
        if (cnt_zero) begin
          sig_d   = stage_q;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
`endif
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      in_q    <= '0;
      cls_q   <= ClsZero;
      mag_q   <= '0;
      rnd_q   <= 1'b0;
      res_q   <= '0;
      sig_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SAMPLE_ALIGN_EN
      stage_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      cls_q   <= cls_d;
      mag_q   <= mag_d;
      rnd_q   <= rnd_d;
      res_q   <= res_d;
      sig_q   <= sig_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef SAMPLE_ALIGN_EN
      stage_q <= stage_d;
`endif
    end
  end

  assign sig16b = sig_q;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_fp64_to_pcm16.sv
// Self-checking bench for fp64_to_pcm16 against a real-arithmetic reference model.
module tb_fp64_to_pcm16;

  logic        clk_operation = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [12:0] sampling_cycle_counter = '0;
  logic [63:0] double = '0;
  logic [15:0] sig16b;
  logic        ready;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk_operation = ~clk_operation;

  fp64_to_pcm16 #(.CNT_W(13)) dut (
    .clk_operation          (clk_operation),
    .rst                    (rst),
    .enable                 (enable),
    .sampling_cycle_counter (sampling_cycle_counter),
    .double                 (double),
    .sig16b                 (sig16b),
    .ready                  (ready),
    .busy                   (busy)
  );

  // Reference: interpret as a real, round half away from zero, clamp to 16 bits
  function automatic logic [15:0] model(input logic [63:0] x);
    real r, a, fl;
    int  m;
    logic [10:0] e;
    e = x[62:52];
    if (e == 11'h7FF) begin
      if (x[51:0] != 52'd0) return 16'h0000;
      return x[63] ? 16'h8000 : 16'h7FFF;
    end
    r = $bitstoreal(x);
    a = (r < 0.0) ? -r : r;
    if (a >= 32768.0) return x[63] ? 16'h8000 : 16'h7FFF;
    fl = $floor(a);
    m  = $rtoi(fl);
    if (a - fl >= 0.5) m = m + 1;
    if (x[63]) return 16'(-m);
    if (m > 32767) m = 32767;
    return 16'(m);
  endfunction

  function automatic logic [63:0] rand_val();
    logic [31:0] a, b;
    logic [10:0] e;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 15))
      0:       e = 11'h7FF;
      1:       e = 11'h000;
      default: e = 11'($urandom_range(1012, 1045));
    endcase
    if (a[30:29] == 2'b00) begin
      b = '0;
      a[7:0] = '0;
    end
    return {a[31], e, a[19:0], b};
  endfunction

  task automatic run_one(input logic [63:0] x, output logic [15:0] got, output int lat,
                         output logic busy_seen, output logic ready_after);
    @(negedge clk_operation);
    double = x;
    enable = 1'b1;
    @(posedge clk_operation);
    #1;
    enable    = 1'b0;
    busy_seen = busy;
    lat       = 0;
    got       = 'x;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_operation);
      #1;
      lat++;
      if (ready) begin
        got = sig16b;
        break;
      end
    end
    @(posedge clk_operation);
    #1;
    ready_after = ready;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    enable = 1'b1;
    double = 64'h3FF0000000000000;
    repeat (3) @(posedge clk_operation);
    #1;
    checks++;
    if (sig16b !== 16'h0000) begin
      failures++;
      $display("FAIL reset_sig16b got=%h exp=0000", sig16b);
    end
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    enable = 1'b0;
    @(negedge clk_operation);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [63:0] vec [13];
    logic [15:0] expv [13];
    logic [15:0] got;
    int          lat;
    logic        bs, ra;
    vec[0]  = 64'h3FF0000000000000; expv[0]  = 16'h0001;
    vec[1]  = 64'hC004000000000000; expv[1]  = 16'hFFFD;
    vec[2]  = 64'h40934A0000000000; expv[2]  = 16'h04D3;
    vec[3]  = 64'h40E3880000000000; expv[3]  = 16'h7FFF;
    vec[4]  = 64'hC0E3880000000000; expv[4]  = 16'h8000;
    vec[5]  = 64'h7FF8000000000000; expv[5]  = 16'h0000;
    vec[6]  = 64'h7FF0000000000000; expv[6]  = 16'h7FFF;
    vec[7]  = 64'hFFF0000000000000; expv[7]  = 16'h8000;
    vec[8]  = 64'h8000000000000000; expv[8]  = 16'h0000;
    vec[9]  = 64'h3FE0000000000000; expv[9]  = 16'h0001;
    vec[10] = 64'h3FDFFFFFFFFFFFFF; expv[10] = 16'h0000;
    vec[11] = 64'h40DFFFE000000000; expv[11] = 16'h7FFF;
    vec[12] = 64'hC0DFFFE000000000; expv[12] = 16'h8000;
    for (int i = 0; i < 13; i++) begin
      run_one(vec[i], got, lat, bs, ra);
      checks++;
      if (got !== expv[i]) begin
        failures++;
        $display("FAIL directed_value[%0d] in=%h got=%h exp=%h", i, vec[i], got, expv[i]);
      end
      checks++;
      if (lat != 4) begin
        failures++;
        $display("FAIL directed_latency[%0d] got=%0d exp=4", i, lat);
      end
      checks++;
      if (bs !== 1'b1) begin
        failures++;
        $display("FAIL directed_busy[%0d] got=%b exp=1", i, bs);
      end
      checks++;
      if (ra !== 1'b0) begin
        failures++;
        $display("FAIL directed_ready_pulse[%0d] got=%b exp=0", i, ra);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] x;
    logic [15:0] got;
    int          lat;
    logic        bs, ra;
    for (int i = 0; i < 300; i++) begin
      x = rand_val();
`ifndef SAMPLE_ALIGN_EN
      sampling_cycle_counter = 13'($urandom);
`endif
      run_one(x, got, lat, bs, ra);
      checks++;
      if (got !== model(x) || lat != 4) begin
        failures++;
        $display("FAIL random[%0d] in=%h got=%h lat=%0d exp=%h lat=4", i, x, got, lat, model(x));
      end
    end
    sampling_cycle_counter = '0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] v [3];
    for (int i = 0; i < 3; i++) v[i] = rand_val();
    @(negedge clk_operation);
    double = v[0];
    enable = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk_operation);
      #1;
      if (k % 5 == 0 && k < 10) double = v[k / 5 + 1];
      checks++;
      if (ready !== (k % 5 == 4)) begin
        failures++;
        $display("FAIL b2b_ready[%0d] got=%b exp=%b", k, ready, (k % 5 == 4));
      end
      if (k % 5 == 4) begin
        checks++;
        if (sig16b !== model(v[k / 5])) begin
          failures++;
          $display("FAIL b2b_value[%0d] got=%h exp=%h", k, sig16b, model(v[k / 5]));
        end
      end
    end
    enable = 1'b0;
    @(posedge clk_operation);
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    int          lat;
    logic        bs, ra;
    run_one(64'h40934A0000000000, got, lat, bs, ra);
    checks++;
    if (got !== 16'h04D3) begin
      failures++;
      $display("FAIL midrst_pre got=%h exp=04d3", got);
    end
    @(negedge clk_operation);
    double = 64'hC004000000000000;
    enable = 1'b1;
    @(posedge clk_operation);
    #1;
    enable = 1'b0;
    @(posedge clk_operation);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (sig16b !== 16'h0000 || ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear got sig=%h rdy=%b busy=%b exp 0000/0/0", sig16b, ready, busy);
    end
    @(negedge clk_operation);
    rst = 1'b1;
    run_one(64'h40E3880000000000, got, lat, bs, ra);
    checks++;
    if (got !== 16'h7FFF || lat != 4) begin
      failures++;
      $display("FAIL midrst_after got=%h lat=%0d exp=7fff lat=4", got, lat);
    end
  endtask

`ifdef SAMPLE_ALIGN_EN
  task automatic test_sample_align();
    logic [15:0] got;
    int          lat;
    logic        bs, ra;
    run_one(64'h3FF0000000000000, got, lat, bs, ra);
    @(negedge clk_operation);
    double = 64'hC004000000000000;
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_operation);
      #1;
      if (k == 0) enable = 1'b0;
      if (k >= 4 && k <= 6) begin
        checks++;
        if (ready !== 1'b0 || sig16b !== 16'h0001 || busy !== 1'b1) begin
          failures++;
          $display("FAIL align_hold[%0d] sig=%h rdy=%b busy=%b exp 0001/0/1", k, sig16b, ready,
                   busy);
        end
      end
      if (k == 7) begin
        checks++;
        if (ready !== 1'b1 || sig16b !== 16'hFFFD || busy !== 1'b0) begin
          failures++;
          $display("FAIL align_xfer sig=%h rdy=%b busy=%b exp fffd/1/0", sig16b, ready, busy);
        end
      end
      sampling_cycle_counter = 13'((k + 2) % 8);
    end
    sampling_cycle_counter = '0;
    @(posedge clk_operation);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef SAMPLE_ALIGN_EN
    test_sample_align();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
